// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM controller between two request ports.
// Optional macro: SRAM_ARB_FIXED_PRIO_EN (port 0 always wins a tie).
// Ports:
//   clk, Resetn                    clock, async active-low reset
//   req/we/addr/wdata 0,1          request side, held until doneN
//   gnt/done/rdata 0,1             winner level, done pulse, read data
//   mem_address/write_data/
//   write_en/read_data/ready       SRAM controller side
//   busy                           high whenever not idle
module sram_port_arbiter #(
    parameter int                ADDR_W       = 18,
    parameter int                DATA_W       = 16,
    parameter logic [ADDR_W-1:0] IDLE_ADDR    = 18'h0FFFF,
    parameter int                BUSY_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              Resetn,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_ready,
    output logic              busy
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_READY,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_sel;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_win;
    logic               w_skip;
    logic               w_cnt_last;
    logic               w_sel_n;
    logic               w_busy_d;
    logic               w_gnt0_d;
    logic               w_gnt1_d;
    logic               w_done0_d;
    logic               w_done1_d;
    logic               w_we_d;
    logic [ADDR_W-1:0]  w_maddr_d;
    logic [DATA_W-1:0]  w_mwd_d;
    logic [DATA_W-1:0]  w_rd0_d;
    logic [DATA_W-1:0]  w_rd1_d;
    logic [DATA_W-1:0]  w_rd_cap;

    // The controller cannot service its own idle address, so such reads
    // complete without touching the SRAM.
    assign w_skip     = (r_addr == IDLE_ADDR);
    assign w_cnt_last = (r_cnt == CNT_W'(BUSY_TIMEOUT - 1));

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign w_win = ~req0;
`else
    logic r_ptr;

    // Tie goes to the pointer; a lone requester wins outright.
    assign w_win = (req0 && req1) ? r_ptr : ~req0;

    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            r_ptr <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_ptr <= ~r_sel;
        end
    end
`endif

    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
            r_sel   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= IDLE_ADDR;
            r_wdata <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_next == S_ISSUE) begin
                r_sel   <= w_win;
                r_we    <= w_win ? we1 : we0;
                r_addr  <= w_win ? addr1 : addr0;
                r_wdata <= w_win ? wdata1 : wdata0;
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT_BUSY) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (req0 || req1) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                w_next = (r_we || w_skip) ? S_DONE : S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!mem_ready || w_cnt_last) w_next = S_WAIT_READY;
            end
            S_WAIT_READY: begin
                if (mem_ready) w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Outputs are registered, so their next values follow the next state.
    always_comb begin
        w_sel_n   = (r_state == S_IDLE) ? w_win : r_sel;
        w_busy_d  = (w_next != S_IDLE);
        w_gnt0_d  = w_busy_d && !w_sel_n;
        w_gnt1_d  = w_busy_d && w_sel_n;
        w_done0_d = (w_next == S_DONE) && !w_sel_n;
        w_done1_d = (w_next == S_DONE) && w_sel_n;
        w_we_d    = 1'b0;
        w_maddr_d = mem_address;
        w_mwd_d   = mem_write_data;
        w_rd0_d   = rdata0;
        w_rd1_d   = rdata1;
        // Skipped reads reach DONE straight from ISSUE and return zero.
        w_rd_cap  = (r_state == S_WAIT_READY) ? mem_read_data : '0;
        unique case (w_next)
            S_ISSUE: begin
                w_we_d    = w_win ? we1 : we0;
                w_maddr_d = w_win ? addr1 : addr0;
                w_mwd_d   = w_win ? wdata1 : wdata0;
            end
            S_DONE, S_IDLE: begin
                w_maddr_d = IDLE_ADDR;
            end
            default: begin
            end
        endcase
        if (w_next == S_DONE && !r_we) begin
            if (w_sel_n) w_rd1_d = w_rd_cap;
            else         w_rd0_d = w_rd_cap;
        end
    end

    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            busy           <= 1'b0;
            gnt0           <= 1'b0;
            gnt1           <= 1'b0;
            done0          <= 1'b0;
            done1          <= 1'b0;
            mem_write_en   <= 1'b0;
            mem_address    <= IDLE_ADDR;
            mem_write_data <= '0;
            rdata0         <= '0;
            rdata1         <= '0;
        end else begin
            busy           <= w_busy_d;
            gnt0           <= w_gnt0_d;
            gnt1           <= w_gnt1_d;
            done0          <= w_done0_d;
            done1          <= w_done1_d;
            mem_write_en   <= w_we_d;
            mem_address    <= w_maddr_d;
            mem_write_data <= w_mwd_d;
            rdata0         <= w_rd0_d;
            rdata1         <= w_rd1_d;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed and random checks of sram_port_arbiter
// against a transaction-level model with a scripted SRAM controller.
module tb_sram_port_arbiter;

    localparam logic [17:0] IDLE_A = 18'h0FFFF;

    logic        clk = 1'b0;
    logic        Resetn = 1'b0;
    logic        req0, req1, we0, we1;
    logic [17:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, done0, done1;
    logic [15:0] rdata0, rdata1;
    logic [17:0] mem_address;
    logic [15:0] mem_write_data;
    logic        mem_write_en;
    logic [15:0] mem_read_data;
    logic        mem_ready;
    logic        busy;

    always #5 clk = ~clk;

    sram_port_arbiter dut (
        .clk(clk), .Resetn(Resetn),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read_data(mem_read_data),
        .mem_ready(mem_ready), .busy(busy)
    );

    // One expected cycle: DUT outputs plus the controller's drive.
    typedef struct {
        logic        busy;
        logic [1:0]  gnt;
        logic [1:0]  done;
        logic [17:0] addr;
        logic        we;
        logic [15:0] wd;
        logic [15:0] rd0;
        logic [15:0] rd1;
        logic        rdy;
        logic [15:0] rdat;
    } rec_t;

    rec_t        sched[$];
    rec_t        cur;
    logic [15:0] m_rd[2];
    logic [15:0] m_wd;
    int          m_last;

    logic        pv[2], preq[2], pacc[2], pwe[2];
    logic [17:0] paddr[2];
    logic [15:0] pwd[2], pD[2];
    int          pk[2], pL[2];

    int errors = 0;
    int checks = 0;
    bit rand_on = 0;
    bit auto_on = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
        end
    endtask

    function automatic rec_t idle_rec();
        rec_t r;
        r.busy = 1'b0; r.gnt = 2'b00; r.done = 2'b00;
        r.addr = IDLE_A; r.we = 1'b0; r.wd = m_wd;
        r.rd0 = m_rd[0]; r.rd1 = m_rd[1];
        r.rdy = 1'($urandom); r.rdat = 16'($urandom);
        return r;
    endfunction

    task automatic compare(input rec_t r);
        chk("busy",  32'(busy),           32'(r.busy));
        chk("gnt0",  32'(gnt0),           32'(r.gnt[0]));
        chk("gnt1",  32'(gnt1),           32'(r.gnt[1]));
        chk("done0", 32'(done0),          32'(r.done[0]));
        chk("done1", 32'(done1),          32'(r.done[1]));
        chk("maddr", 32'(mem_address),    32'(r.addr));
        chk("mwe",   32'(mem_write_en),   32'(r.we));
        chk("mwd",   32'(mem_write_data), 32'(r.wd));
        chk("rd0",   32'(rdata0),         32'(r.rd0));
        chk("rd1",   32'(rdata1),         32'(r.rd1));
    endtask

    // Expand one accepted request into its cycle-by-cycle timeline.
    // k: WAIT_BUSY cycle in which ready falls (>4 never falls there);
    // L: cycles until ready returns in WAIT_READY.
    task automatic build(input int p);
        rec_t r;
        int   nwb;
        m_wd = pwd[p];
        r = idle_rec();
        r.busy = 1'b1;
        r.gnt  = (p == 1) ? 2'b10 : 2'b01;
        r.addr = paddr[p]; r.we = pwe[p]; r.wd = m_wd;
        sched.push_back(r);
        r.we = 1'b0;
        if (!pwe[p] && paddr[p] != IDLE_A) begin
            nwb = (pk[p] <= 4) ? pk[p] : 4;
            for (int i = 1; i <= nwb; i++) begin
                r.rdy = (i < pk[p]);
                r.rdat = 16'($urandom);
                sched.push_back(r);
            end
            for (int j = 1; j <= pL[p]; j++) begin
                r.rdy = (j == pL[p]);
                r.rdat = (j == pL[p]) ? pD[p] : 16'($urandom);
                sched.push_back(r);
            end
            m_rd[p] = pD[p];
        end else if (!pwe[p]) begin
            m_rd[p] = 16'h0;
        end
        r.done = r.gnt; r.addr = IDLE_A;
        r.rd0 = m_rd[0]; r.rd1 = m_rd[1];
        r.rdy = 1'($urandom); r.rdat = 16'($urandom);
        sched.push_back(r);
        r = idle_rec();
        sched.push_back(r);
        m_last = p;
    endtask

    task automatic raise(input int p, input logic we, input logic [17:0] a,
                         input logic [15:0] wd, input int k, input int l,
                         input logic [15:0] d);
        pv[p] = 1'b1; preq[p] = 1'b1; pacc[p] = 1'b0;
        pwe[p] = we; paddr[p] = a; pwd[p] = wd;
        pk[p] = k; pL[p] = l; pD[p] = d;
    endtask

    task automatic raise_rand(input int p);
        logic [17:0] a;
        a = 18'($urandom);
        if ($urandom_range(0, 7) == 0) a = IDLE_A;
        raise(p, 1'($urandom), a, 16'($urandom),
              int'($urandom_range(1, 6)), int'($urandom_range(1, 3)),
              16'($urandom));
    endtask

    task automatic drive();
        req0 = pv[0] & preq[0]; we0 = pwe[0];
        addr0 = paddr[0]; wdata0 = pwd[0];
        req1 = pv[1] & preq[1]; we1 = pwe[1];
        addr1 = paddr[1]; wdata1 = pwd[1];
    endtask

    task automatic advance();
        int w;
        if (sched.size() == 0 && Resetn && (req0 || req1)) begin
            if (req0 && req1) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
                w = 0;
`else
                w = (m_last == 1) ? 0 : 1;
`endif
            end else begin
                w = req1 ? 1 : 0;
            end
            pacc[w] = 1'b1;
            build(w);
        end
        if (sched.size() > 0) cur = sched.pop_front();
        else cur = idle_rec();
    endtask

    task automatic step();
        @(negedge clk);
        compare(cur);
        mem_ready = cur.rdy;
        mem_read_data = cur.rdat;
        for (int p = 0; p < 2; p++) begin
            if (cur.done[p]) begin
                pv[p] = 1'b0; pacc[p] = 1'b0;
            end
            if (!pv[p] && auto_on)
                raise(p, 1'b1, 18'($urandom), 16'($urandom), 1, 1, 16'h0);
            else if (!pv[p] && rand_on && $urandom_range(0, 2) == 0)
                raise_rand(p);
            else if (pacc[p] && rand_on && $urandom_range(0, 5) == 0)
                preq[p] = 1'b0;
        end
        drive();
        advance();
    endtask

    task automatic wait_done(input int p, input int maxn, output int n);
        n = -1;
        for (int i = 1; i <= maxn; i++) begin
            step();
            if ((p == 0 ? done0 : done1) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic model_reset();
        sched.delete();
        m_rd[0] = 16'h0; m_rd[1] = 16'h0; m_wd = 16'h0; m_last = 1;
        for (int p = 0; p < 2; p++) begin
            pv[p] = 1'b0; preq[p] = 1'b0; pacc[p] = 1'b0;
        end
        cur = idle_rec();
        drive();
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (sched.size() == 0 && !pv[0] && !pv[1]) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("drain", 32'(ok), 32'd1);
    endtask

    initial begin
        int n;
        int order[$];
        int ord_exp[4];
        for (int p = 0; p < 2; p++) begin
            pwe[p] = 1'b0; paddr[p] = 18'h0; pwd[p] = 16'h0;
            pk[p] = 1; pL[p] = 1; pD[p] = 16'h0;
        end
        mem_ready = 1'b1;
        mem_read_data = 16'h0;
        model_reset();

        // Reset held while port 0 already requests a write.
        raise(0, 1'b1, 18'h00010, 16'hBEEF, 1, 1, 16'h0);
        drive();
        repeat (2) @(negedge clk);
        chk("rst_addr", 32'(mem_address), 32'(IDLE_A));
        chk("rst_we", 32'(mem_write_en), 32'd0);
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_done0", 32'(done0), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 Resetn = 1'b1;
        step();
        step();
        chk("wr_we", 32'(mem_write_en), 32'd1);
        chk("wr_addr", 32'(mem_address), 32'h00010);
        chk("wr_data", 32'(mem_write_data), 32'hBEEF);
        step();
        chk("wr_done0", 32'(done0), 32'd1);

        // Port 1 read, ready low for 3 cycles.
        raise(1, 1'b0, 18'h00020, 16'h0, 1, 3, 16'h1234);
        step();
        wait_done(1, 20, n);
        chk("rd_lat", 32'(n), 32'd6);
        chk("rd_rdata1", 32'(rdata1), 32'h1234);
        chk("rd_rdata0", 32'(rdata0), 32'h0);

        // Ready never falls: timeout into WAIT_READY.
        raise(0, 1'b0, 18'h00040, 16'h0, 9, 1, 16'h5A5A);
        step();
        wait_done(0, 20, n);
        chk("to_lat", 32'(n), 32'd7);
        chk("to_rdata0", 32'(rdata0), 32'h5A5A);
        chk("to_rdata1", 32'(rdata1), 32'h1234);

        // Read of the idle address is skipped.
        raise(0, 1'b0, IDLE_A, 16'h0, 1, 1, 16'hFFFF);
        step();
        step();
        chk("snt_addr", 32'(mem_address), 32'(IDLE_A));
        chk("snt_we", 32'(mem_write_en), 32'd0);
        step();
        chk("snt_done", 32'(done0), 32'd1);
        chk("snt_rdata", 32'(rdata0), 32'h0);

        // Reset while waiting for ready.
        raise(1, 1'b0, 18'h00030, 16'h0, 1, 6, 16'h7777);
        step();
        repeat (3) step();
        Resetn = 1'b0;
        #1;
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_gnt1", 32'(gnt1), 32'd0);
        chk("mr_addr", 32'(mem_address), 32'(IDLE_A));
        chk("mr_rdata1", 32'(rdata1), 32'h0);
        model_reset();
        repeat (2) step();
        @(posedge clk);
        #1 Resetn = 1'b1;
        n = 0;
        repeat (6) begin
            step();
            if (done1 === 1'b1) n++;
        end
        chk("mr_nodone", 32'(n), 32'd0);

        // Both ports held high: grant order.
`ifdef SRAM_ARB_FIXED_PRIO_EN
        ord_exp = '{0, 0, 0, 0};
`else
        ord_exp = '{0, 1, 0, 1};
`endif
        auto_on = 1'b1;
        for (int i = 0; i < 100 && order.size() < 4; i++) begin
            step();
            if (done0 === 1'b1) order.push_back(0);
            if (done1 === 1'b1) order.push_back(1);
        end
        auto_on = 1'b0;
        for (int i = 0; i < 4; i++)
            chk($sformatf("order%0d", i),
                32'((order.size() > i) ? order[i] : -1), 32'(ord_exp[i]));
        drain();

        // Random traffic against the model.
        rand_on = 1'b1;
        repeat (3000) step();
        rand_on = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Shares the single SRAM controller between two requesters: port 0 (memory stage) and port 1 (instruction fetch / secondary master). Each request is latched and presented to the controller as one clean transaction. The block sequences the controller's ready-based read timing and returns read data plus a one-cycle done pulse to the winner. Sits between the pipeline memory ports and the SRAM controller's memory-stage interface.

Parameters:
ADDR_W, 18, address width on all ports
DATA_W, 16, data width on all ports
IDLE_ADDR, 18'h0FFFF, address driven to controller when no transaction is active; the controller treats it as "no access"
BUSY_TIMEOUT, 4, max cycles in WAIT_BUSY waiting for mem_ready to fall

Ports:
clk  in  1  clock; all state changes on rising edge
Resetn  in  1  asynchronous, active-low reset
req0 / req1  in  1  request, held until doneN
we0 / we1  in  1  1=write, 0=read; held with reqN
addr0 / addr1  in  ADDR_W  request address
wdata0 / wdata1  in  DATA_W  write data
gnt0 / gnt1  out  1  winner indication, level, ISSUE through DONE
done0 / done1  out  1  one-cycle completion pulse
rdata0 / rdata1  out  DATA_W  read data, valid with doneN, held until next read completion on that port
mem_address  out  ADDR_W  to controller SRAM_address
mem_write_data  out  DATA_W  to controller SRAM_write_data
mem_write_en  out  1  to controller SRAM_write_en
mem_read_data  in  DATA_W  from controller SRAM_read_data
mem_ready  in  1  from controller ready
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, Resetn=0): state IDLE; mem_address=IDLE_ADDR; mem_write_data=0; mem_write_en=0; gnt*/done*=0; rdata*=0; busy=0; round-robin pointer favours port 0.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_READY, DONE. All outputs registered.
- IDLE: if any req, pick winner, latch addr/wdata/we, -> ISSUE. Both req: pointer-favoured port wins. One req: that port wins regardless of pointer.
- ISSUE (1 cycle): mem_address=latched addr, mem_write_en=latched we, mem_write_data=latched wdata; gntN=1. Write -> DONE. Read -> WAIT_BUSY.
- WAIT_BUSY: mem_write_en=0, address held; mem_ready=0 -> WAIT_READY; after BUSY_TIMEOUT cycles with mem_ready=1 -> WAIT_READY anyway (counter cleared on entry).
- WAIT_READY: mem_ready=1 -> capture mem_read_data into rdataN, -> DONE.
- DONE (1 cycle): doneN=1; mem_address=IDLE_ADDR, mem_write_en=0; pointer set to favour the other port; -> IDLE; gnt drops on exit.
- Latency: write done 2 cycles after accept edge; read done ≥4 cycles after accept.
- Read to addr==IDLE_ADDR: controller cannot service; skip SRAM, go ISSUE->DONE with rdataN=0, mem_write_en=0, mem_address stays IDLE_ADDR. Writes to IDLE_ADDR issued normally.
- reqN dropped mid-transaction: transaction still completes, doneN still pulses; no abort.
- reqN still high in the cycle after doneN: treated as new request, re-arbitrated (other port wins if also requesting).
- rdata of the non-winning port never changes.
- Reset asserted mid-operation: immediate return to reset values; in-flight transaction lost, no done.

Optional Feature:
SRAM_ARB_FIXED_PRIO_EN: defined -> port 0 always wins simultaneous requests, pointer unused (port 1 may starve). Undefined -> round-robin as above.

Test Plan:
- Reset: Resetn=0 with req0=1 -> mem_address=18'h0FFFF, mem_write_en=0, gnt/done=0, busy=0; release, req0 write addr 18'h00010 data 16'hBEEF -> mem_write_en=1 one cycle, done0 2 cycles after accept.
- Read: req1 read addr 18'h00020, controller model drops ready 3 cycles returning 16'h1234 -> rdata1=16'h1234 with done1, rdata0 unchanged.
- Contention: req0 and req1 held high for 4 transactions -> grant order 0,1,0,1 (macro off); 0,0,0,0 with SRAM_ARB_FIXED_PRIO_EN.
- Timeout: read where mem_ready never falls -> WAIT_READY after 4 cycles, done0 with captured mem_read_data.
- Sentinel: read addr 18'h0FFFF -> done in 2 cycles, rdata=0, mem_address stays 18'h0FFFF.
- Mid-op reset: Resetn low in WAIT_READY -> outputs at reset values immediately, no done pulse.
